// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding,
// fetch-queue entry layout and boot constants.
package ifetch_pkg;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_fq.sv
// Synchronous fetch queue: power-of-two depth, clear beats push/pop,
// push into a full queue is accepted only together with a pop.
module ifetch_fq #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clr_i,
    input  logic [W-1:0]           din_i,
    output logic [W-1:0]           dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == DEPTH_C);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    // Storage carries no reset; consumers qualify it with empty_o.
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// IF-stage sequencer: boot-loader/fetch arbitration of imem, fetch address
// generation, read-latency absorption via ifetch_fq, redirects and ID stalls.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          FQ_DEPTH = 2,
    parameter int          IMEM_AW  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        boot_en,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] imem_addr,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rdata
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

    if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0 || IMEM_AW < 1 || IMEM_AW > 30) begin : g_param_check
        $error("ifetch_ctrl: FQ_DEPTH must be a power of two >= 2 and IMEM_AW in 1..30");
    end

    state_t      state_q;
    logic [31:0] fpc_q;
    logic [31:0] fpc_d;
    logic [31:0] ipc_q;
    logic        inflight_q;

    logic          fetch;
    logic          flush;
    logic          pop;
    logic          push;
    logic          issue;
    logic          room;
    logic [CW-1:0] occ;
    logic          fq_full;
    logic          fq_empty;
    logic [CW-1:0] fq_count;
    fq_entry_t     push_ent;
    fq_entry_t     head_ent;

    assign fetch = (state_q == ST_FETCH);
    // Leaving for the loader or redirecting both discard everything queued or in flight.
    assign flush = fetch && (boot_en || redir_valid);
    assign pop   = !fq_empty && id_ready && !flush;
    assign push  = fetch && inflight_q && !flush && (!fq_full || pop);

    // A same-cycle pop frees a slot, which keeps one instruction per cycle flowing.
    assign occ   = fq_count + CW'(inflight_q);
    assign room  = occ < (DEPTH_C + CW'(pop));
    assign issue = fetch && !flush && room;
    assign fpc_d = fpc_q + 32'd4;

    assign push_ent = '{pc: ipc_q, instr: imem_rdata};

    ifetch_fq #(
        .DEPTH (FQ_DEPTH),
        .W     (64)
    ) u_fq (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (pop),
        .clr_i   (flush),
        .din_i   (push_ent),
        .dout_o  (head_ent),
        .full_o  (fq_full),
        .empty_o (fq_empty),
        .count_o (fq_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_LOAD;
            fpc_q      <= RESET_PC;
            ipc_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (!boot_en) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (boot_en) begin
                        state_q    <= ST_LOAD;
                        fpc_q      <= RESET_PC;
                        inflight_q <= 1'b0;
                    end else if (redir_valid) begin
                        fpc_q      <= word_align(redir_pc);
                        inflight_q <= 1'b0;
                    end else begin
                        inflight_q <= issue;
                        if (issue) begin
                            ipc_q <= fpc_q;
                            fpc_q <= fpc_d;
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    // Every output is forced low while reset is held, independent of the clock.
    always_comb begin
        ld_ready   = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        if_valid   = 1'b0;
        if_pc      = '0;
        if_instr   = '0;
        if (reset) begin
            if (state_q == ST_LOAD) begin
                ld_ready   = ld_valid;
                imem_we    = ld_valid;
                imem_addr  = ld_addr;
                imem_wdata = ld_data;
            end else begin
                imem_addr  = fpc_q;
            end
            if (!fq_empty) begin
                if_valid = 1'b1;
                if_pc    = head_ent.pc;
                if_instr = head_ent.instr;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: imem model, program-order fetch model checked every
// cycle, and directed boot / stall / redirect / wrap / reset scenarios.
module tb_ifetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        boot_en;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ifetch_ctrl #(
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (2),
        .IMEM_AW  (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .boot_en     (boot_en),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .imem_addr   (imem_addr),
        .imem_we     (imem_we),
        .imem_wdata  (imem_wdata),
        .imem_rdata  (imem_rdata)
    );

    // Synchronous 1024-word imem, wraps by word index.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr[11:2]] <= imem_wdata;
        else         imem_rdata <= mem[imem_addr[11:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Program-order model: whatever is presented must be the next instruction
    // after the last accepted one (or the redirect/boot target), read from imem.
    logic [31:0] exp_pc     = RESET_PC;
    logic        after_redir = 1'b0;
    logic        prev_stall  = 1'b0;
    logic [31:0] stall_pc    = '0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_if_valid", 32'(if_valid), 32'h0);
            chk("rst_if_pc", if_pc, 32'h0);
            chk("rst_imem_we", 32'(imem_we), 32'h0);
            exp_pc      = RESET_PC;
            after_redir = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            if (after_redir) chk("valid_after_redirect", 32'(if_valid), 32'h0);
            if (prev_stall) begin
                chk("stall_valid_hold", 32'(if_valid), 32'h1);
                chk("stall_pc_hold", if_pc, stall_pc);
            end
            if (if_valid) begin
                chk("order_pc", if_pc, exp_pc);
                chk("order_instr", if_instr, mem[exp_pc[11:2]]);
            end
            if (!ld_valid) chk("imem_we_idle", 32'(imem_we), 32'h0);
            after_redir = redir_valid && !boot_en;
            prev_stall  = if_valid && !id_ready && !redir_valid && !boot_en;
            stall_pc    = if_pc;
            if (boot_en)               exp_pc = RESET_PC;
            else if (redir_valid)      exp_pc = redir_pc & 32'hFFFF_FFFC;
            else if (if_valid && id_ready) exp_pc = exp_pc + 32'd4;
        end
    end

    initial begin
        reset       = 1'b0;
        boot_en     = 1'b1;
        ld_valid    = 1'b1;
        ld_addr     = 32'h0000_0044;
        ld_data     = 32'hDEAD_BEEF;
        redir_valid = 1'b0;
        redir_pc    = '0;
        id_ready    = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);

        // Reset values, loader request must not leak through
        #3;
        chk("reset_ld_ready", 32'(ld_ready), 32'h0);
        chk("reset_imem_we", 32'(imem_we), 32'h0);
        chk("reset_imem_addr", imem_addr, 32'h0);
        chk("reset_imem_wdata", imem_wdata, 32'h0);
        chk("reset_if_instr", if_instr, 32'h0);
        #9 reset = 1'b1;

        // 1: boot load then fetch from RESET_PC
        tick();
        ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'h0000_0013;
        #1;
        chk("load_ld_ready", 32'(ld_ready), 32'h1);
        chk("load_imem_we", 32'(imem_we), 32'h1);
        chk("load_imem_addr", imem_addr, 32'h0);
        chk("load_imem_wdata", imem_wdata, 32'h0000_0013);
        tick();
        ld_addr = 32'h4; ld_data = 32'h0010_0093;
        tick();
        ld_valid = 1'b0;
        #1 chk("load_idle_ready", 32'(ld_ready), 32'h0);
        boot_en = 1'b0; id_ready = 1'b1;
        tick();
        chk("fetch_issue0_addr", imem_addr, 32'h0);
        chk("fetch_c0_valid", 32'(if_valid), 32'h0);
        tick();
        chk("fetch_c1_valid", 32'(if_valid), 32'h0);
        chk("fetch_issue1_addr", imem_addr, 32'h4);
        tick();
        chk("first_valid", 32'(if_valid), 32'h1);
        chk("first_pc", if_pc, 32'h0);
        chk("first_instr", if_instr, 32'h0000_0013);
        tick();
        chk("second_pc", if_pc, 32'h4);
        chk("second_instr", if_instr, 32'h0010_0093);
        tick();
        chk("third_pc", if_pc, 32'h8);
        id_ready = 1'b0;

        // 2: back-pressure
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_pc", if_pc, 32'h8);
        end
        chk("bp_fpc_hold", imem_addr, 32'h10);
        id_ready = 1'b1;
        #1 chk("bp_release_pc", if_pc, 32'h8);
        tick(); chk("bp_next_c", if_pc, 32'hC);
        tick(); chk("bp_next_10", if_pc, 32'h10);
        tick(); chk("bp_next_14", if_pc, 32'h14);

        // 3: redirect while queue full, then unaligned target
        id_ready = 1'b0;
        repeat (3) tick();
        redir_valid = 1'b1; redir_pc = 32'h40;
        tick();
        redir_valid = 1'b0;
        #1;
        chk("redir_bubble", 32'(if_valid), 32'h0);
        chk("redir_issue_addr", imem_addr, 32'h40);
        tick(); chk("redir_capture_bubble", 32'(if_valid), 32'h0);
        tick();
        chk("redir_pc", if_pc, 32'h40);
        chk("redir_instr", if_instr, 32'hC0DE_0010);
        repeat (2) tick();
        redir_valid = 1'b1; redir_pc = 32'h43;
        tick();
        redir_valid = 1'b0;
        #1 chk("redir_align_addr", imem_addr, 32'h40);
        tick(); tick();
        chk("redir_align_pc", if_pc, 32'h40);

        // 4: redirect coincident with pop and capture
        id_ready = 1'b1;
        repeat (4) tick();
        chk("stream_valid", 32'(if_valid), 32'h1);
        redir_valid = 1'b1; redir_pc = 32'h80;
        tick();
        redir_valid = 1'b0;
        #1 chk("redir_wins_empty", 32'(if_valid), 32'h0);
        tick(); tick();
        chk("redir80_pc", if_pc, 32'h80);

        // 5: address wrap
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
        tick();
        redir_valid = 1'b0;
        tick(); tick();
        chk("wrap_top_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_top_instr", if_instr, 32'hC0DE_03FF);
        tick();
        chk("wrap_zero_pc", if_pc, 32'h0);
        chk("wrap_zero_instr", if_instr, 32'h0000_0013);
        tick();
        chk("wrap_four_pc", if_pc, 32'h4);

        // 6: async reset between clock edges
        tick();
        #2;
        reset = 1'b0; boot_en = 1'b1;
        ld_valid = 1'b1; ld_addr = 32'h44; ld_data = 32'hC0DE_0011;
        #1;
        chk("arst_if_valid", 32'(if_valid), 32'h0);
        chk("arst_if_pc", if_pc, 32'h0);
        chk("arst_if_instr", if_instr, 32'h0);
        chk("arst_imem_addr", imem_addr, 32'h0);
        chk("arst_imem_we", 32'(imem_we), 32'h0);
        chk("arst_ld_ready", 32'(ld_ready), 32'h0);
        tick();
        reset = 1'b1;
        #1 chk("arst_back_in_load", 32'(ld_ready), 32'h1);
        tick();
        ld_valid = 1'b0; boot_en = 1'b0;
        tick(); tick(); tick();
        chk("restart_pc", if_pc, RESET_PC);
        chk("restart_instr", if_instr, 32'h0000_0013);
        tick();
        chk("restart_next_pc", if_pc, 32'h4);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
